// File: rtl/eq_band_scheduler_if.sv
// Bus bundle for the EQ band scheduler: sample input, shared-engine
// handshake, per-band/audio results and status flags.
// The slave view belongs to the scheduler; the master view belongs to whatever drives it.
interface eq_band_scheduler_if #(
  parameter int DATA_W = 16
);
  logic                     sample_valid_i;
  logic signed [DATA_W-1:0] sample_i;
  logic [2:0]               band_en_i;
  logic                     clr_i;

  logic                     eng_start_o;
  logic [1:0]               eng_band_o;
  logic signed [DATA_W-1:0] eng_x_o;
  logic                     eng_done_i;
  logic signed [DATA_W-1:0] eng_y_i;
  logic                     eng_abort_o;

  logic signed [DATA_W-1:0] low_o;
  logic signed [DATA_W-1:0] mid_o;
  logic signed [DATA_W-1:0] high_o;
  logic signed [DATA_W-1:0] audio_o;
  logic                     audio_valid_o;
  logic                     busy_o;
  logic                     overrun_o;
  logic                     fault_o;

  modport slave (
    input  sample_valid_i, sample_i, band_en_i, clr_i, eng_done_i, eng_y_i,
    output eng_start_o, eng_band_o, eng_x_o, eng_abort_o,
           low_o, mid_o, high_o, audio_o, audio_valid_o,
           busy_o, overrun_o, fault_o
  );

  modport master (
    output sample_valid_i, sample_i, band_en_i, clr_i, eng_done_i, eng_y_i,
    input  eng_start_o, eng_band_o, eng_x_o, eng_abort_o,
           low_o, mid_o, high_o, audio_o, audio_valid_o,
           busy_o, overrun_o, fault_o
  );
endinterface

// File: rtl/eq_band_scheduler.sv
// Three-band EQ scheduler: time-shares one filter engine across the
// enabled bands of each sample, then sums the band results with saturation.
module eq_band_scheduler #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic                lmmi_clk_i,
  input logic                reset_n_i,
  eq_band_scheduler_if.slave bus
);

  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BAND = 2'd1, S_SUM = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               band, band_nxt;
  logic [2:0]               mask_q;
  logic [CNT_W-1:0]         wait_cnt;
  logic signed [DATA_W-1:0] x_q, low_q, mid_q, high_q, audio_q;
  logic                     audio_vld_q, overrun_q, fault_q;
  logic                     accept, drop, start, done_ok, tmo, band_end;
  logic [2:0]               first_nb, next_nb;
  logic signed [DATA_W+1:0] sum_w;

  // Lowest enabled band at index >= lo, returned as {found, index}.
  function automatic logic [2:0] pick_band(input logic [2:0] m, input int lo);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (m[i] && i >= lo) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Clamp the widened sum back to DATA_W: in range only if the top three bits agree.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W+1:0] v);
    if ((v[DATA_W+1:DATA_W-1] == 3'b000) || (v[DATA_W+1:DATA_W-1] == 3'b111))
      return v[DATA_W-1:0];
    else if (v[DATA_W+1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // The start cycle is the only BAND cycle with a zero wait count, so done is
  // only honoured afterwards; done wins over a timeout landing in the same cycle.
  assign accept   = (state == S_IDLE) && bus.sample_valid_i;
  assign drop     = (state != S_IDLE) && bus.sample_valid_i;
  assign start    = (state == S_BAND) && (wait_cnt == '0);
  assign done_ok  = (state == S_BAND) && !start && bus.eng_done_i;
  assign tmo      = (state == S_BAND) && !start && !bus.eng_done_i && (wait_cnt == TMO);
  assign band_end = done_ok || tmo;
  assign first_nb = pick_band(bus.band_en_i, 0);
  assign next_nb  = pick_band(mask_q, int'(band) + 1);
  assign sum_w    = {{2{low_q[DATA_W-1]}},  low_q}
                  + {{2{mid_q[DATA_W-1]}},  mid_q}
                  + {{2{high_q[DATA_W-1]}}, high_q};

  // State register with the current band index.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= S_IDLE;
      band  <= 2'd0;
    end else begin
      state <= state_nxt;
      band  <= band_nxt;
    end
  end

  // Next state: walk the enabled bands in ascending order, then SUM for one cycle.
  always_comb begin
    state_nxt = state;
    band_nxt  = band;
    case (state)
      S_IDLE: begin
        if (bus.sample_valid_i) begin
          if (first_nb[2]) begin
            state_nxt = S_BAND;
            band_nxt  = first_nb[1:0];
          end else begin
            state_nxt = S_SUM;
          end
        end
      end
      S_BAND: begin
        if (band_end) begin
          if (next_nb[2]) begin
            band_nxt = next_nb[1:0];
          end else begin
            state_nxt = S_SUM;
          end
        end
      end
      S_SUM:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM-decoded outputs toward the engine and status.
  always_comb begin
    bus.eng_start_o = start;
    bus.eng_abort_o = tmo;
    bus.eng_band_o  = (state == S_BAND) ? band : 2'd0;
    bus.busy_o      = (state != S_IDLE);
  end

  // Sample latch, band results, wait counter, audio sum and sticky flags.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      x_q         <= '0;
      mask_q      <= '0;
      low_q       <= '0;
      mid_q       <= '0;
      high_q      <= '0;
      audio_q     <= '0;
      audio_vld_q <= 1'b0;
      wait_cnt    <= '0;
      overrun_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      audio_vld_q <= (state == S_SUM);
      if (state == S_SUM) audio_q <= sat(sum_w);
      if (accept) begin
        x_q    <= bus.sample_i;
        mask_q <= bus.band_en_i;
        if (!bus.band_en_i[0]) low_q  <= '0;
        if (!bus.band_en_i[1]) mid_q  <= '0;
        if (!bus.band_en_i[2]) high_q <= '0;
      end
      if (band_end) begin
        case (band)
          2'd0:    low_q  <= done_ok ? bus.eng_y_i : '0;
          2'd1:    mid_q  <= done_ok ? bus.eng_y_i : '0;
          default: high_q <= done_ok ? bus.eng_y_i : '0;
        endcase
      end
      if ((state != S_BAND) || band_end) wait_cnt <= '0;
      else                               wait_cnt <= wait_cnt + CNT_W'(1);
      overrun_q <= drop || (overrun_q && !bus.clr_i);
      fault_q   <= tmo  || (fault_q   && !bus.clr_i);
    end
  end

  assign bus.eng_x_o       = x_q;
  assign bus.low_o         = low_q;
  assign bus.mid_o         = mid_q;
  assign bus.high_o        = high_q;
  assign bus.audio_o       = audio_q;
  assign bus.audio_valid_o = audio_vld_q;
  assign bus.overrun_o     = overrun_q;
  assign bus.fault_o       = fault_q;

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Scoreboard bench for eq_band_scheduler: a stimulus process pushes the
// expected per-sample result, a negedge monitor pops and compares.
module tb_eq_band_scheduler;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 20;
  localparam int MAXV    = 2 ** (DATA_W - 1) - 1;
  localparam int MINV    = -(2 ** (DATA_W - 1));

  logic lmmi_clk_i = 1'b0;
  logic reset_n_i  = 1'b0;

  eq_band_scheduler_if #(.DATA_W(DATA_W)) bus();

  eq_band_scheduler #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .lmmi_clk_i (lmmi_clk_i),
    .reset_n_i  (reset_n_i),
    .bus        (bus)
  );

  always #5 lmmi_clk_i = ~lmmi_clk_i;

  typedef struct {
    int audio;
    int lo;
    int mi;
    int hi;
    int acc_cyc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   start_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   abort_cnt = 0;
  int   cur_x = 0;
  int   cur_y[3];
  int   cur_dly[3];

  always @(posedge lmmi_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"},   bus.eng_start_o,   0);
    check({tag, "_band"},    bus.eng_band_o,    0);
    check({tag, "_x"},       bus.eng_x_o,       0);
    check({tag, "_abort"},   bus.eng_abort_o,   0);
    check({tag, "_low"},     bus.low_o,         0);
    check({tag, "_mid"},     bus.mid_o,         0);
    check({tag, "_high"},    bus.high_o,        0);
    check({tag, "_audio"},   bus.audio_o,       0);
    check({tag, "_avalid"},  bus.audio_valid_o, 0);
    check({tag, "_busy"},    bus.busy_o,        0);
    check({tag, "_overrun"}, bus.overrun_o,     0);
    check({tag, "_fault"},   bus.fault_o,       0);
  endtask

  // Engine model: done (with the band's value) d cycles after start, never if d==0;
  // junk done pulses in start cycles and idle cycles must be ignored.
  initial begin : engine
    int  left;
    int  b;
    bit  armed;
    armed = 0;
    left  = 0;
    b     = 0;
    bus.eng_done_i = 1'b0;
    bus.eng_y_i    = '0;
    forever begin
      @(posedge lmmi_clk_i);
      #1;
      bus.eng_done_i = 1'b0;
      bus.eng_y_i    = DATA_W'($urandom);
      if (!reset_n_i) begin
        armed = 0;
      end else begin
        if (armed) begin
          left--;
          if (left == 0) begin
            bus.eng_done_i = 1'b1;
            bus.eng_y_i    = DATA_W'(cur_y[b]);
            armed = 0;
          end
        end
        if (bus.eng_start_o) begin
          b = int'(bus.eng_band_o);
          if (cur_dly[b] > 0) begin
            armed = 1;
            left  = cur_dly[b];
          end
          if ($urandom_range(0, 1) == 1) bus.eng_done_i = 1'b1;
        end else if (!bus.busy_o && $urandom_range(0, 3) == 0) begin
          bus.eng_done_i = 1'b1;
        end
      end
    end
  end

  // Monitor: engine starts/aborts and every audio_valid_o against the scoreboard.
  always @(negedge lmmi_clk_i) begin
    if (reset_n_i) begin
      if (bus.eng_start_o) begin
        if (start_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_start: band %0d started, none expected (cycle %0d)", bus.eng_band_o, cyc);
        end else begin
          check("eng_band", bus.eng_band_o, start_q.pop_front());
          check("eng_x", bus.eng_x_o, cur_x);
        end
        start_cyc = cyc;
      end
      if (bus.eng_abort_o) begin
        abort_cnt++;
        check("abort_delay", cyc - start_cyc, TIMEOUT);
      end
      if (bus.audio_valid_o) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_audio_valid: audio %0d, none expected (cycle %0d)", bus.audio_o, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("audio",   bus.audio_o, e.audio);
          check("low",     bus.low_o,   e.lo);
          check("mid",     bus.mid_o,   e.mi);
          check("high",    bus.high_o,  e.hi);
          check("latency", cyc - e.acc_cyc, e.lat);
        end
      end
    end
  end

  // Wait for idle, present one sample, and record what the spec says must come out.
  task automatic send(input int x, input logic [2:0] m,
                      input int y0, input int y1, input int y2,
                      input int d0, input int d1, input int d2);
    exp_t e;
    int   yv[3];
    int   dv[3];
    int   bv[3];
    int   g;
    int   s;
    yv = '{y0, y1, y2};
    dv = '{d0, d1, d2};
    g  = 0;
    do begin
      @(posedge lmmi_clk_i);
      #1;
      g++;
    end while (bus.busy_o && g < 5000);
    if (bus.busy_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_wait: busy_o still %0d after %0d cycles, required 0", bus.busy_o, g);
    end
    bus.sample_valid_i = 1'b1;
    bus.sample_i       = DATA_W'(x);
    bus.band_en_i      = m;
    cur_x   = x;
    cur_y   = yv;
    cur_dly = dv;
    e.acc_cyc = cyc;
    e.lat     = 2;
    for (int i = 0; i < 3; i++) begin
      bv[i] = 0;
      if (m[i]) begin
        start_q.push_back(i);
        e.lat += (dv[i] == 0) ? TIMEOUT + 1 : dv[i] + 1;
        if (dv[i] != 0) bv[i] = yv[i];
      end
    end
    s = bv[0] + bv[1] + bv[2];
    e.audio = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
    e.lo = bv[0];
    e.mi = bv[1];
    e.hi = bv[2];
    sb.push_back(e);
    @(posedge lmmi_clk_i);
    #1;
    bus.sample_valid_i = 1'b0;
  endtask

  // A sample offered while busy; optionally with clr_i in the same cycle.
  task automatic drop_sample(input logic clr);
    @(posedge lmmi_clk_i);
    #1;
    bus.sample_valid_i = 1'b1;
    bus.sample_i       = DATA_W'($urandom);
    bus.band_en_i      = 3'($urandom);
    bus.clr_i          = clr;
    @(posedge lmmi_clk_i);
    #1;
    bus.sample_valid_i = 1'b0;
    bus.clr_i          = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge lmmi_clk_i);
    #1;
    bus.clr_i = 1'b1;
    @(posedge lmmi_clk_i);
    #1;
    bus.clr_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 5000) begin
      @(posedge lmmi_clk_i);
      g++;
    end
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding after %0d cycles, required 0", sb.size(), g);
      sb.delete();
      start_q.delete();
    end
    #1;
  endtask

  function automatic int rand_y();
    if ($urandom_range(0, 3) == 0)
      return ($urandom_range(0, 1) == 1) ? MAXV - int'($urandom_range(0, 4095))
                                         : MINV + int'($urandom_range(0, 4095));
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin : stim
    bus.sample_valid_i = 1'b1;
    bus.sample_i       = 16'sh1234;
    bus.band_en_i      = 3'b111;
    bus.clr_i          = 1'b0;
    cur_y   = '{0, 0, 0};
    cur_dly = '{1, 1, 1};

    repeat (3) @(posedge lmmi_clk_i);
    #1;
    check_zero("reset");
    @(negedge lmmi_clk_i);
    bus.sample_valid_i = 1'b0;
    reset_n_i = 1'b1;
    repeat (5) @(posedge lmmi_clk_i);

    // Nominal three-band case, saturation both ways, sparse and empty masks, back to back.
    send(16'h1000, 3'b111, 16'h0100, 16'h0200, 16'h0300, 1, 1, 1);
    send(16'h0123, 3'b111, 16'h7000, 16'h7000, 16'h7000, 1, 1, 1);
    send(16'h0456, 3'b111, -28672, -28672, -28672, 1, 1, 1);
    send(16'h0111, 3'b101, 16'h0111, 16'h0222, 16'h0333, 1, 1, 1);
    send(-5, 3'b000, 16'h0444, 16'h0555, 16'h0666, 1, 1, 1);
    drain();
    check("overrun_after_back_to_back", bus.overrun_o, 0);
    check("fault_before_timeout", bus.fault_o, 0);

    // Engine silent on the mid band.
    send(16'h0777, 3'b111, 16'h0010, 16'h0020, 16'h0030, 1, 0, 1);
    drain();
    check("abort_count", abort_cnt, 1);
    check("fault_set", bus.fault_o, 1);
    pulse_clr();
    check("fault_cleared", bus.fault_o, 0);

    // Overrun: dropped sample, clear, then set and clear in the same cycle.
    send(16'h0abc, 3'b111, 16'h0001, 16'h0002, 16'h0003, 1, 1, 1);
    drop_sample(1'b0);
    check("overrun_set", bus.overrun_o, 1);
    pulse_clr();
    check("overrun_cleared", bus.overrun_o, 0);
    drain();
    send(-1000, 3'b011, 16'h0100, -300, 16'h0005, 2, 3, 1);
    drop_sample(1'b1);
    check("overrun_set_wins_clr", bus.overrun_o, 1);
    drain();
    pulse_clr();

    // Randomized traffic with occasional timeouts.
    for (int t = 0; t < 40; t++) begin
      int d[3];
      for (int i = 0; i < 3; i++)
        d[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
      send(rand_y(), 3'($urandom), rand_y(), rand_y(), rand_y(), d[0], d[1], d[2]);
    end
    drain();

    // Reset mid-BAND.
    send(16'h0321, 3'b111, 16'h0100, 16'h0100, 16'h0100, 3, 3, 3);
    repeat (2) @(posedge lmmi_clk_i);
    #3;
    sb.delete();
    start_q.delete();
    reset_n_i = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (2) @(posedge lmmi_clk_i);
    @(negedge lmmi_clk_i);
    reset_n_i = 1'b1;
    repeat (30) @(posedge lmmi_clk_i);
    #1;
    check("idle_after_reset", bus.busy_o, 0);
    send(16'h0042, 3'b110, 16'h0007, 16'h0008, 16'h0009, 1, 2, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eq_band_scheduler.md
EQ_BAND_SCHEDULER -- requirements
Module: eq_band_scheduler

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, giving the signed sample and band-result width.
REQ-002 The module SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for eng_done_i after eng_start_o.
REQ-003 lmmi_clk_i  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset_n_i  input  1  reset, asynchronous and active-low.
REQ-005 sample_valid_i  input  1  one-cycle pulse; a new mono sample is present on sample_i.
REQ-006 sample_i  input  DATA_W  signed input sample.
REQ-007 band_en_i  input  3  band enable mask; bit0 is low, bit1 is mid, bit2 is high.
REQ-008 clr_i  input  1  synchronous clear of the sticky flags.
REQ-009 eng_start_o  output  1  one-cycle start pulse to the shared filter engine.
REQ-010 eng_band_o  output  2  band select to the engine: 0 is low, 1 is mid, 2 is high.
REQ-011 eng_x_o  output  DATA_W  latched sample presented to the engine.
REQ-012 eng_done_i  input  1  engine result-valid pulse.
REQ-013 eng_y_i  input  DATA_W  signed engine result.
REQ-014 eng_abort_o  output  1  one-cycle pulse issued on timeout.
REQ-015 low_o, mid_o, high_o  output  DATA_W each  registered per-band results.
REQ-016 audio_o  output  DATA_W  registered saturated sum of the three band results.
REQ-017 audio_valid_o  output  1  one-cycle pulse; audio_o has been updated.
REQ-018 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-019 overrun_o  output  1  sticky flag: a sample was dropped.
REQ-020 fault_o  output  1  sticky flag: an engine timeout occurred.

Function
REQ-021 The FSM SHALL have three states: IDLE, BAND (with a band-index register) and SUM.
REQ-022 In IDLE, sample_valid_i SHALL latch sample_i into eng_x_o and band_en_i into an internal mask; the next state is BAND at the lowest enabled band, or SUM if the mask is 0.
REQ-023 Disabled bands SHALL be skipped without an engine start, and their band register SHALL be written with 0.
REQ-024 eng_start_o SHALL be high only in the first cycle of each BAND visit; eng_band_o SHALL hold the current index for the whole visit.
REQ-025 eng_done_i SHALL be ignored in the start cycle and in every state other than BAND.
REQ-026 eng_done_i in BAND after the start cycle SHALL capture eng_y_i into the current band register and advance to the next enabled band, or to SUM after the highest enabled band.
REQ-027 A wait counter SHALL count cycles after the start cycle; on reaching TIMEOUT without eng_done_i, the block SHALL write the band register with 0, set fault_o, pulse eng_abort_o for one cycle and advance as in REQ-026.
REQ-028 SUM SHALL last one cycle and form low+mid+high at DATA_W+2 bits signed, saturating to DATA_W: above 2^(DATA_W-1)-1 gives 0x7FFF, below -2^(DATA_W-1) gives 0x8000 (values for DATA_W=16).
REQ-029 audio_o SHALL be registered at the end of SUM; audio_valid_o SHALL pulse in the following cycle, in which the FSM is already in IDLE.
REQ-030 A sample_valid_i in that IDLE cycle SHALL be accepted normally.
REQ-031 A sample_valid_i while the FSM is not in IDLE SHALL be dropped and SHALL set overrun_o; the operation in progress is unaffected.
REQ-032 clr_i SHALL clear overrun_o and fault_o; if a set event and clr_i occur in the same cycle, the flag SHALL end set.
REQ-033 Latency SHALL be 2*k+2 cycles from accept to audio_valid_o, where k is the number of enabled bands and the engine returns done one cycle after start (8 cycles for k=3, 2 cycles for k=0).

Reset
REQ-034 Asserting reset_n_i low at any time, including mid-BAND, SHALL immediately return the FSM to IDLE.
REQ-035 During reset, all outputs, band registers, counters, the mask and both sticky flags SHALL be 0.
REQ-036 No eng_start_o SHALL be issued until a sample is accepted after reset release.

Verification
REQ-037 Mask 3'b111, sample 0x1000, engine returns 0x0100/0x0200/0x0300 one cycle after each start -> audio_o 0x0600, audio_valid_o exactly 8 cycles after accept, eng_band_o sequence 0,1,2.
REQ-038 Bands each return 0x7000 -> audio_o 0x7FFF; bands each return 0x9000 -> audio_o 0x8000.
REQ-039 Mask 3'b101 -> exactly two starts with band 0 then band 2, mid_o 0, latency 6 cycles; mask 3'b000 -> no starts, audio_o 0, latency 2 cycles.
REQ-040 Engine never asserts done for band 1 -> eng_abort_o after TIMEOUT cycles, mid_o 0, fault_o set, band 2 still processed; clr_i then clears fault_o.
REQ-041 sample_valid_i during BAND -> overrun_o set, the result equals the first sample's result; sample_valid_i coincident with audio_valid_o -> accepted, overrun_o stays 0.
REQ-042 reset_n_i pulsed low mid-BAND -> all outputs 0 in the same cycle, IDLE on release, no spurious audio_valid_o.
